serial_monitor: RTL and testbench
=================================

# serial_monitor

Serial-to-bus debug master. Parses binary read/write commands arriving from the UART receiver, issues single-word transactions as an extra initiator on the bus controller, and returns results through the UART transmitter. It gives the host word-level peek/poke access to external SRAM and peripherals without CPU involvement, and is used for bring-up and image download.

## Interface
- FREQ, 40_000_000: clock frequency in Hz; scales the timeout.
- TIMEOUT_MS, 100: inter-byte timeout in ms; only used with SERIAL_MONITOR_TIMEOUT_EN.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- rs232in_attention  in  1  one-cycle pulse; new received byte on rs232in_data.
- rs232in_data  in  8  received byte; valid while rs232in_attention is high.
- rs232out_busy  in  1  transmitter busy.
- rs232out_w  out  1  one-cycle write strobe to the transmitter.
- rs232out_d  out  8  transmit byte; valid with rs232out_w.
- bus_a  out  32  word address; bits [1:0] always 0.
- bus_r  out  1  read request.
- bus_w  out  1  write request.
- bus_wd  out  32  write data.
- bus_wbe  out  4  byte enables; always 4'hF on writes, 4'h0 otherwise.
- bus_wait  in  1  target or arbiter stall; the request is held while high.
- bus_rd_valid  in  1  one-cycle pulse; read data on bus_rd.
- bus_rd  in  32  read data.

## Operation
- Command bytes:
  - 'R' (0x52) is followed by 4 address bytes, MSB first.
  - 'W' (0x57) is followed by 4 address bytes, then 4 data bytes, all MSB first.
  - Any other opcode byte gets the reply '?' (0x3F); the FSM returns to IDLE.
- Replies:
  - Read: 4 data bytes, MSB first.
  - Write: 'K' (0x4B) after the write is accepted.
- States:
  - IDLE: waits for an opcode byte.
  - ADDR: collects 4 bytes into a 32-bit shift register.
  - DATA: write only; collects 4 bytes.
  - ISSUE: drives the request.
  - RDWAIT: waits for bus_rd_valid.
  - TX: sends the reply bytes.
- Address bits [1:0] from the host are forced to 0 on bus_a.
- ISSUE:
  - Asserts bus_r or bus_w, and keeps it asserted with stable bus_a, bus_wd and bus_wbe while bus_wait is high.
  - The request is accepted in the first cycle it is asserted with bus_wait low.
  - bus_r and bus_w deassert the next cycle.
  - After a read, go to RDWAIT. After a write, go to TX with reply 'K'.
- RDWAIT: on the bus_rd_valid pulse, capture bus_rd, then go to TX with a byte count of 4.
- TX:
  - Pulse rs232out_w only in a cycle where rs232out_busy is low and no strobe was issued the previous cycle.
  - After the last byte, return to IDLE.
- Received bytes are ignored in ISSUE, RDWAIT and TX; there is no buffering.
- Reset mid-operation: the partial command and any pending reply are discarded. An accepted-but-unreturned read is dropped; a bus_rd_valid pulse arriving after reset is ignored in IDLE.

## Timing
- Reset values:
  - bus_r, bus_w and rs232out_w are 0.
  - bus_a, bus_wd and rs232out_d are 0.
  - bus_wbe is 0.
  - The state is IDLE.
- Request latency: bus_r or bus_w asserts 1 cycle after the attention pulse of the final command byte.
- Write reply: the first rs232out_w comes no earlier than 1 cycle after acceptance.
- Read reply: the first rs232out_w comes no earlier than 1 cycle after bus_rd_valid.
- Inter-strobe spacing: at least 2 cycles, further gated by rs232out_busy.
- Outstanding requests: at most one at any time.
- A bus_rd_valid pulse outside RDWAIT is ignored.

## Configuration
- SERIAL_MONITOR_TIMEOUT_EN defined:
  - In ADDR or DATA, a counter of FREQ/1000*TIMEOUT_MS cycles restarts on every received byte.
  - On expiry, the partial command is discarded silently and the FSM returns to IDLE.
  - The counter is inactive in other states.
- Undefined: no counter; a partial command waits indefinitely.

## Test plan
- Write: send 57 40 00 01 00 DE AD BE EF with bus_wait held low.
  - bus_w pulses once with bus_a=0x4000_0100, bus_wd=0xDEADBEEF, bus_wbe=4'hF.
  - Reply: 0x4B.
- Read: send 52 40 00 01 03, with bus_rd=0x12345678 returned 3 cycles after acceptance.
  - bus_r is issued with bus_a=0x4000_0100.
  - Reply: 12 34 56 78.
- Stall: hold bus_wait high for 10 cycles during a write.
  - bus_w and bus_a stay stable for 11 cycles.
  - Exactly one write is accepted, followed by one 'K'.
- Back-pressure: hold rs232out_busy high for 50 cycles during a read reply.
  - No strobe is issued while busy.
  - All 4 bytes are delivered in order.
- Bad opcode and reset: send 0x41.
  - Reply: 0x3F.
  - Then assert rst after 'R' plus 2 address bytes: all outputs return to 0, and a following full read command works normally.
- Timeout (macro defined, FREQ=1_000_000, TIMEOUT_MS=1): send 57 40, idle 1100 cycles, then 52 40 00 00 00.
  - No write is issued.
  - The read is issued with bus_a=0x4000_0000.

Source files
------------

// File: rtl/serial_monitor_if.sv
// serial_monitor_if
//   Single-word bus between the serial debug master and the bus controller.
//   master modport : drives bus_a/bus_r/bus_w/bus_wd/bus_wbe,
//                    samples bus_wait/bus_rd_valid/bus_rd.
//   slave modport  : the bus controller side (mirror image).
//   bus_a is a word address (bits [1:0] zero); bus_wbe is 4'hF only while
//   bus_w is asserted. A request is held while bus_wait is high and is
//   accepted in the first cycle it is seen with bus_wait low.
interface serial_monitor_if;
  logic [31:0] bus_a;
  logic        bus_r;
  logic        bus_w;
  logic [31:0] bus_wd;
  logic [3:0]  bus_wbe;
  logic        bus_wait;
  logic        bus_rd_valid;
  logic [31:0] bus_rd;

  modport master (
    output bus_a, bus_r, bus_w, bus_wd, bus_wbe,
    input  bus_wait, bus_rd_valid, bus_rd
  );

  modport slave (
    input  bus_a, bus_r, bus_w, bus_wd, bus_wbe,
    output bus_wait, bus_rd_valid, bus_rd
  );
endinterface

// File: rtl/serial_monitor.sv
// serial_monitor
//   Serial-to-bus debug master. Parses binary commands from the UART
//   receiver, performs one single-word bus transaction per command and sends
//   the result back through the UART transmitter.
//     'R' a3 a2 a1 a0             -> reply d3 d2 d1 d0 (read data, MSB first)
//     'W' a3 a2 a1 a0 d3 d2 d1 d0 -> reply 'K' once the write is accepted
//     any other opcode            -> reply '?'
//   Ports:
//     clk, rst           : clock and synchronous active-high reset
//     rs232in_attention  : one-cycle strobe, rs232in_data holds a new byte
//     rs232out_busy      : transmitter busy; rs232out_w/rs232out_d write it
//     bus                : serial_monitor_if.master bus initiator port
//   Parameters:
//     FREQ, TIMEOUT_MS   : size the inter-byte timeout (FREQ/1000*TIMEOUT_MS
//                          cycles), active only when the macro
//                          SERIAL_MONITOR_TIMEOUT_EN is defined. Without it a
//                          partial command waits indefinitely.
module serial_monitor #(
  parameter int unsigned FREQ       = 40_000_000,
  parameter int unsigned TIMEOUT_MS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rs232in_attention,
  input  logic [7:0]       rs232in_data,
  input  logic             rs232out_busy,
  output logic             rs232out_w,
  output logic [7:0]       rs232out_d,
  serial_monitor_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_RDWAIT, S_TX
  } state_e;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RPL_ERR  = 8'h3F;
  localparam logic [7:0] RPL_OK   = 8'h4B;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  cnt_q, cnt_d;          // byte index inside ADDR / DATA
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] tx_buf_q, tx_buf_d;    // reply, next byte in [31:24]
  logic [2:0]  tx_left_q, tx_left_d;  // reply bytes still to send
  logic        bus_r_q, bus_r_d;
  logic        bus_w_q, bus_w_d;
  logic        tx_w_q, tx_w_d;
  logic [7:0]  tx_d_q, tx_d_d;
  logic        timeout;

`ifdef SERIAL_MONITOR_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = FREQ / 1000 * TIMEOUT_MS;

  // Counts idle cycles since the last received byte while a command is
  // being collected; held at zero everywhere else.
  logic [31:0] timer_q, timer_d;
  logic        collecting;

  assign collecting = (state_q == S_ADDR) || (state_q == S_DATA);

  always_comb begin
    timer_d = '0;
    if (collecting && !rs232in_attention) begin
      timer_d = timer_q + 32'd1;
    end
  end

  assign timeout = collecting && !rs232in_attention &&
                   (timer_q >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_buf_d   = tx_buf_q;
    tx_left_d  = tx_left_q;
    bus_r_d    = bus_r_q;
    bus_w_d    = bus_w_q;
    tx_w_d     = 1'b0;
    tx_d_d     = tx_d_q;

    case (state_q)
      S_IDLE: begin
        if (rs232in_attention) begin
          cnt_d = 2'd0;
          if (rs232in_data == OP_READ) begin
            is_write_d = 1'b0;
            state_d    = S_ADDR;
          end else if (rs232in_data == OP_WRITE) begin
            is_write_d = 1'b1;
            state_d    = S_ADDR;
          end else begin
            tx_buf_d  = {RPL_ERR, 24'h0};
            tx_left_d = 3'd1;
            state_d   = S_TX;
          end
        end
      end

      S_ADDR: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else if (rs232in_attention) begin
          addr_d = {addr_q[23:0], rs232in_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_write_q) begin
              state_d = S_DATA;
            end else begin
              // Request goes out on the cycle right after the last byte.
              bus_r_d = 1'b1;
              state_d = S_ISSUE;
            end
          end
        end
      end

      S_DATA: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else if (rs232in_attention) begin
          wdata_d = {wdata_q[23:0], rs232in_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            bus_w_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // Accepted on the first cycle the request is seen with bus_wait low.
        if (!bus.bus_wait) begin
          bus_r_d = 1'b0;
          bus_w_d = 1'b0;
          if (is_write_q) begin
            tx_buf_d  = {RPL_OK, 24'h0};
            tx_left_d = 3'd1;
            state_d   = S_TX;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end

      S_RDWAIT: begin
        if (bus.bus_rd_valid) begin
          tx_buf_d  = bus.bus_rd;
          tx_left_d = 3'd4;
          state_d   = S_TX;
        end
      end

      S_TX: begin
        // Skipping the cycle after a strobe gives the transmitter time to
        // raise busy before the next byte is offered.
        if (!rs232out_busy && !tx_w_q) begin
          tx_w_d    = 1'b1;
          tx_d_d    = tx_buf_q[31:24];
          tx_buf_d  = {tx_buf_q[23:0], 8'h0};
          tx_left_d = tx_left_q - 3'd1;
          if (tx_left_q == 3'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_buf_q   <= '0;
      tx_left_q  <= '0;
      bus_r_q    <= 1'b0;
      bus_w_q    <= 1'b0;
      tx_w_q     <= 1'b0;
      tx_d_q     <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_buf_q   <= tx_buf_d;
      tx_left_q  <= tx_left_d;
      bus_r_q    <= bus_r_d;
      bus_w_q    <= bus_w_d;
      tx_w_q     <= tx_w_d;
      tx_d_q     <= tx_d_d;
    end
  end

  assign bus.bus_a   = {addr_q[31:2], 2'b00};
  assign bus.bus_r   = bus_r_q;
  assign bus.bus_w   = bus_w_q;
  assign bus.bus_wd  = wdata_q;
  assign bus.bus_wbe = bus_w_q ? 4'hF : 4'h0;
  assign rs232out_w  = tx_w_q;
  assign rs232out_d  = tx_d_q;

endmodule

// File: tb/tb_serial_monitor.sv
// tb_serial_monitor
//   Randomized self-checking bench for serial_monitor. A bus target model
//   answers requests (random stalls and read latencies), a transmitter model
//   applies busy back-pressure, and a command-level reference model predicts
//   the bus transaction and reply bytes of each command.
module tb_serial_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       attn;
  logic [7:0] rxd;
  logic       busy;
  logic       tx_w;
  logic [7:0] tx_d;

  serial_monitor_if bus_if ();

  serial_monitor #(
    .FREQ       (1_000_000),
    .TIMEOUT_MS (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rs232in_attention (attn),
    .rs232in_data      (rxd),
    .rs232out_busy     (busy),
    .rs232out_w        (tx_w),
    .rs232out_d        (tx_d),
    .bus               (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- environment state ----------------
  typedef struct packed {
    logic        is_w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  wbe;
  } bus_txn_t;

  bus_txn_t    bus_log[$];
  logic [7:0]  rx_q[$];
  logic [31:0] target_mem [logic [31:0]];
  logic [31:0] model_mem  [logic [31:0]];
  int          req_cycles  = 0;
  int          stall_hold  = 0;
  int          busy_hold   = 0;
  bit          rand_wait   = 0;
  bit          rand_busy   = 0;
  bit          rd_lat_rand = 0;
  int          rd_lat      = 3;
  bit          stray_req   = 0;
  bit          busy_on_last = 0;

  logic [7:0]  cmd_buf [9];
  int          cmd_len;

  function automatic logic [31:0] fill_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- bus target ----------------
  initial begin
    bit          held;
    logic [31:0] h_a, h_wd;
    logic [3:0]  h_wbe;
    logic        h_r, h_w;
    int          rd_cnt;
    logic [31:0] rd_data;
    bus_txn_t    t;
    held = 0; rd_cnt = 0; rd_data = '0;
    h_a = '0; h_wd = '0; h_wbe = '0; h_r = 0; h_w = 0;
    bus_if.bus_wait = 1'b0;
    bus_if.bus_rd_valid = 1'b0;
    bus_if.bus_rd = '0;
    forever begin
      @(negedge clk);
      bus_if.bus_rd_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus_if.bus_rd_valid = 1'b1;
          bus_if.bus_rd = rd_data;
        end
      end else if (stray_req) begin
        stray_req = 0;
        bus_if.bus_rd_valid = 1'b1;
        bus_if.bus_rd = $urandom;
      end
      if (stall_hold > 0 && (bus_if.bus_r || bus_if.bus_w)) begin
        bus_if.bus_wait = 1'b1;
        stall_hold--;
      end else begin
        bus_if.bus_wait = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (rst) begin
        held = 0;
      end else if (bus_if.bus_r || bus_if.bus_w) begin
        req_cycles++;
        check("req_both", 32'(bus_if.bus_r & bus_if.bus_w), 32'h0);
        if (held) begin
          check("hold_a",   bus_if.bus_a,  h_a);
          check("hold_wd",  bus_if.bus_wd, h_wd);
          check("hold_wbe", 32'(bus_if.bus_wbe), 32'(h_wbe));
          check("hold_rw",  32'({bus_if.bus_r, bus_if.bus_w}), 32'({h_r, h_w}));
        end
        if (!bus_if.bus_wait) begin
          t.is_w = bus_if.bus_w;
          t.a    = bus_if.bus_a;
          t.wd   = bus_if.bus_wd;
          t.wbe  = bus_if.bus_wbe;
          bus_log.push_back(t);
          if (bus_if.bus_w) begin
            target_mem[bus_if.bus_a] = bus_if.bus_wd;
          end else begin
            rd_cnt  = rd_lat_rand ? int'($urandom_range(1, 8)) : rd_lat;
            rd_data = target_mem.exists(bus_if.bus_a) ? target_mem[bus_if.bus_a]
                                                      : fill_word(bus_if.bus_a);
          end
          held = 0;
        end else begin
          held = 1;
          h_a = bus_if.bus_a; h_wd = bus_if.bus_wd; h_wbe = bus_if.bus_wbe;
          h_r = bus_if.bus_r; h_w = bus_if.bus_w;
        end
      end else begin
        if (held) check("req_dropped_while_wait", 32'h0, 32'h1);
        held = 0;
      end
    end
  end

  // ---------------- transmitter model ----------------
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_hold > 0) begin
        busy = 1'b1;
        busy_hold--;
      end else begin
        busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
    end
  end

  initial begin
    logic prev_w;
    prev_w = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_w) begin
        check("tx_spacing", 32'(prev_w), 32'h0);
        check("tx_while_busy", 32'(busy), 32'h0);
        rx_q.push_back(tx_d);
      end
      prev_w = tx_w;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    attn = 1'b1;
    rxd  = b;
    @(negedge clk);
    attn = 1'b0;
    rxd  = 8'($urandom);
  endtask

  task automatic build_read(input logic [31:0] a);
    cmd_buf[0] = 8'h52;
    for (int i = 0; i < 4; i++) cmd_buf[1+i] = a[31-8*i -: 8];
    cmd_len = 5;
  endtask

  task automatic build_write(input logic [31:0] a, input logic [31:0] d);
    cmd_buf[0] = 8'h57;
    for (int i = 0; i < 4; i++) cmd_buf[1+i] = a[31-8*i -: 8];
    for (int i = 0; i < 4; i++) cmd_buf[5+i] = d[31-8*i -: 8];
    cmd_len = 9;
  endtask

  task automatic build_bad(input logic [7:0] op);
    cmd_buf[0] = op;
    cmd_len = 1;
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_bus_r"},  32'(bus_if.bus_r), 32'h0);
    check({tag, "_bus_w"},  32'(bus_if.bus_w), 32'h0);
    check({tag, "_tx_w"},   32'(tx_w), 32'h0);
    check({tag, "_bus_a"},  bus_if.bus_a, 32'h0);
    check({tag, "_bus_wd"}, bus_if.bus_wd, 32'h0);
    check({tag, "_tx_d"},   32'(tx_d), 32'h0);
    check({tag, "_wbe"},    32'(bus_if.bus_wbe), 32'h0);
  endtask

  // Sends cmd_buf[start..cmd_len-1] and checks the command against the
  // reference model: at most one bus transaction and a fixed reply.
  task automatic run_cmd(input int start, input int gap_max);
    logic [7:0]  op;
    logic [31:0] a, d, exp_word;
    logic [7:0]  exp_reply[$];
    int          exp_reqs, log0, waited;
    bit          exp_w;
    string       kind;
    bus_txn_t    t;
    op = cmd_buf[0];
    a = '0; d = '0; exp_w = 0; exp_reqs = 0;
    exp_reply.delete();
    if (op == 8'h52 && cmd_len == 5) begin
      a = {cmd_buf[1], cmd_buf[2], cmd_buf[3], cmd_buf[4]} & 32'hFFFF_FFFC;
      exp_word = model_mem.exists(a) ? model_mem[a] : fill_word(a);
      for (int i = 3; i >= 0; i--) exp_reply.push_back(exp_word[8*i +: 8]);
      d = exp_word; exp_reqs = 1; kind = "RD";
    end else if (op == 8'h57 && cmd_len == 9) begin
      a = {cmd_buf[1], cmd_buf[2], cmd_buf[3], cmd_buf[4]} & 32'hFFFF_FFFC;
      d = {cmd_buf[5], cmd_buf[6], cmd_buf[7], cmd_buf[8]};
      model_mem[a] = d;
      exp_reply.push_back(8'h4B);
      exp_w = 1; exp_reqs = 1; kind = "WR";
    end else begin
      exp_reply.push_back(8'h3F);
      kind = "BAD";
    end
    log0 = bus_log.size();
    rx_q.delete();
    for (int i = start; i < cmd_len; i++) send_byte(cmd_buf[i], int'($urandom_range(0, gap_max)));
    if (busy_on_last) busy_hold = 50;
    check("req_latency", 32'(bus_if.bus_r | bus_if.bus_w), 32'(exp_reqs));
    waited = 0;
    while (rx_q.size() < exp_reply.size() && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) check("reply_timeout", 32'(rx_q.size()), 32'(exp_reply.size()));
    if (busy_on_last) check("busy_delay_ok", 32'(waited >= 45), 32'h1);
    idle(6);
    check("reply_len", 32'(rx_q.size()), 32'(exp_reply.size()));
    for (int i = 0; i < exp_reply.size(); i++) begin
      check("reply_byte", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hXXXX_XXXX, 32'(exp_reply[i]));
    end
    check("req_count", 32'(bus_log.size() - log0), 32'(exp_reqs));
    if (exp_reqs == 1 && bus_log.size() > log0) begin
      t = bus_log[log0];
      check("req_kind", 32'(t.is_w), 32'(exp_w));
      check("req_addr", t.a, a);
      if (exp_w) check("req_wdata", t.wd, d);
      check("req_wbe", 32'(t.wbe), exp_w ? 32'hF : 32'h0);
    end
    $display("[TB] cmd %s op=%02h addr=%08h data=%08h reply_bytes=%0d", kind, op, a, d, rx_q.size());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [7:0]  op;
    int          rc0, log0, waited, k;
    rst = 1'b1; attn = 1'b0; rxd = 8'h00;
    repeat (4) @(negedge clk);
    check_outputs_idle("reset");
    rst = 1'b0;
    idle(2);

    // Read with a known word returned 3 cycles after acceptance.
    model_mem[32'h4000_0100]  = 32'h1234_5678;
    target_mem[32'h4000_0100] = 32'h1234_5678;
    rd_lat = 3;
    build_read(32'h4000_0103);
    run_cmd(0, 0);

    // Plain write.
    build_write(32'h4000_0100, 32'hDEAD_BEEF);
    run_cmd(0, 0);

    // Write stalled by bus_wait for 10 cycles.
    rc0 = req_cycles;
    stall_hold = 10;
    build_write(32'h4000_0204, 32'h0BAD_F00D);
    run_cmd(0, 0);
    check("stall_req_cycles", 32'(req_cycles - rc0), 32'd11);

    // Read reply under 50 cycles of transmitter back-pressure.
    busy_on_last = 1;
    build_read(32'h4000_0100);
    run_cmd(0, 0);
    busy_on_last = 0;

    // Unknown opcode.
    build_bad(8'h41);
    run_cmd(0, 0);

    // Reset after 'R' plus two address bytes.
    send_byte(8'h52, 0);
    send_byte(8'h40, 1);
    send_byte(8'h00, 1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_idle("rst_mid_cmd");
    rst = 1'b0;
    idle(2);
    build_read(32'h4000_0204);
    run_cmd(0, 1);

    // Reset while waiting for read data; the late data must be ignored.
    rd_lat = 20;
    build_read(32'h4000_0100);
    log0 = bus_log.size();
    for (int i = 0; i < cmd_len; i++) send_byte(cmd_buf[i], 0);
    waited = 0;
    while (bus_log.size() == log0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("rdwait_req_seen", 32'(bus_log.size() - log0), 32'd1);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_idle("rst_rdwait");
    rst = 1'b0;
    rx_q.delete();
    idle(30);
    check("rst_drops_reply", 32'(rx_q.size()), 32'd0);
    rd_lat = 3;
    run_cmd(0, 0);

`ifdef SERIAL_MONITOR_TIMEOUT_EN
    // Partial write abandoned by the inter-byte timeout.
    log0 = bus_log.size();
    rx_q.delete();
    send_byte(8'h57, 0);
    send_byte(8'h40, 0);
    idle(1100);
    check("timeout_no_req", 32'(bus_log.size() - log0), 32'd0);
    check("timeout_no_reply", 32'(rx_q.size()), 32'd0);
    build_read(32'h4000_0000);
    run_cmd(0, 0);
`else
    // Without the timeout a partial command simply resumes.
    build_write(32'h4000_0100, 32'h1122_3344);
    send_byte(cmd_buf[0], 0);
    send_byte(cmd_buf[1], 0);
    idle(1100);
    run_cmd(2, 0);
`endif

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      rand_wait   = 1'($urandom_range(0, 1));
      rand_busy   = 1'($urandom_range(0, 1));
      rd_lat_rand = 1;
      if ($urandom_range(0, 3) == 0) begin
        stray_req = 1;
        idle(3);
      end
      k = int'($urandom_range(0, 9));
      a = {8'h40, 18'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if (k < 5) begin
        build_read(a);
      end else if (k < 9) begin
        build_write(a, $urandom);
      end else begin
        op = 8'($urandom);
        while (op == 8'h52 || op == 8'h57) op = 8'($urandom);
        build_bad(op);
      end
      run_cmd(0, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
